// File: rtl/div_iter_ctrl.sv
// Sequential signed restoring divider, one quotient bit per clock.
// Ports: clock, reset (async, active-low), ctrl_DIV start, operands A/B; result, exception, RDY pulse, busy.
module div_iter_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             sign;
  logic             dz;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             b_zero;

  // Magnitudes are unsigned, so |-2^(W-1)| = 2^(W-1) fits.
  always_comb begin
    abs_a  = data_operandA[WIDTH-1] ? -data_operandA
                                    : data_operandA;
    abs_b  = data_operandB[WIDTH-1] ? -data_operandB
                                    : data_operandB;
    b_zero = (data_operandB == '0);
    rem_sh = {rem, quo[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvs};
  end

  assign busy = (state == RUN);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      rem            <= '0;
      quo            <= '0;
      dvs            <= '0;
      sign           <= 1'b0;
      dz             <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_DIV) begin
        quo            <= abs_a;
        dvs            <= abs_b;
        rem            <= '0;
        cnt            <= '0;
        sign           <= data_operandA[WIDTH-1]
                        ^ data_operandB[WIDTH-1];
        dz             <= b_zero;
        data_exception <= 1'b0;
        state          <= b_zero ? DONE : RUN;
      end else begin
        case (state)
          RUN: begin
            // Negative trial (MSB set) means restore.
            rem <= trial[WIDTH] ? rem_sh[WIDTH-1:0]
                                : trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= DONE;
          end
          DONE: begin
            data_result    <= dz   ? '0
                            : sign ? -quo : quo;
            data_exception <= dz;
            data_resultRDY <= 1'b1;
            state          <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_iter_ctrl.sv
// Scoreboard bench for div_iter_ctrl.
// Starts are queued with expected result/latency; RDY pops and compares.
module tb_div_iter_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          st;
    int          lat;
    int          nb_exp;
    int          nb;
  } exp_t;

  exp_t q[$];
  int   edge_n = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  div_iter_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edge_n <= edge_n + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] ma, mb, qq;
    ma = a[31] ? -a : a;
    mb = b[31] ? -b : b;
    qq = ma / mb;
    return (a[31] ^ b[31]) ? -qq : qq;
  endfunction

  // Monitor: busy-cycle count, RDY pop/compare, stray RDY.
  always @(negedge clock) begin
    if (q.size() > 0 && edge_n >= q[0].st && busy)
      q[0].nb = q[0].nb + 1;
    if (data_resultRDY) begin
      if (q.size() == 0) begin
        chk("spurious_rdy", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", data_result, e.res);
        chk("exception", {31'd0, data_exception}, {31'd0, e.exc});
        chk("latency", edge_n - e.st, e.lat);
        chk("busy_cycles", e.nb, e.nb_exp);
        chk("busy_at_rdy", {31'd0, busy}, 32'd0);
      end
    end
  end

  // Any new start (or reset) discards the outstanding expectation.
  task automatic start(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic exc);
    exp_t e;
    @(negedge clock);
    ctrl_DIV      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    e.res    = res;
    e.exc    = exc;
    e.st     = edge_n + 1;
    e.lat    = exc ? 1 : 33;
    e.nb_exp = exc ? 0 : 32;
    e.nb     = 0;
    q.delete();
    q.push_back(e);
    @(negedge clock);
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 80 && q.size() > 0; i++)
      @(negedge clock);
    if (q.size() > 0) begin
      chk("timeout", 32'd1, 32'd0);
      q.delete();
    end
    @(negedge clock);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input logic exc);
    start(a, b, res, exc);
    wait_idle();
    chk("held_result", data_result, res);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_result", data_result, 32'd0);
    chk("rst_exc", {31'd0, data_exception}, 32'd0);
    chk("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    run(32'd100, 32'd7, 32'd14, 1'b0);
    run(32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0);
    run(32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0);
    run(32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 1'b0);

    run(32'd5, 32'd0, 32'd0, 1'b1);
    repeat (3) @(negedge clock);
    chk("exc_held", {31'd0, data_exception}, 32'd1);
    chk("busy_after_dz", {31'd0, busy}, 32'd0);

    start(32'd9, 32'd3, 32'd3, 1'b0);
    chk("exc_cleared", {31'd0, data_exception}, 32'd0);
    chk("busy_run", {31'd0, busy}, 32'd1);
    wait_idle();

    run(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run(32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 1'b0);
    run(32'd3, 32'd5, 32'd0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 28);
      if (b == 0) b = 32'd3;
      run(a, b, model(a, b), 1'b0);
    end

    // Restart at edge 10: only the second operation reports.
    start(32'd100, 32'd7, 32'd14, 1'b0);
    repeat (8) @(negedge clock);
    start(32'd50, 32'd5, 32'd10, 1'b0);
    wait_idle();
    repeat (2) @(negedge clock);

    // Asynchronous reset in the middle of a run.
    start(32'd1000, 32'd3, 32'd333, 1'b0);
    repeat (14) @(negedge clock);
    #2;
    reset = 1'b0;
    q.delete();
    #1;
    chk("arst_result", data_result, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_rdy", {31'd0, data_resultRDY}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    run(32'd77, 32'd11, 32'd7, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
